// File: rtl/axi_port_arbiter_pkg.sv
// Shared encodings for the AXI port arbiter: FSM states, owner codes and transfer direction.
package axi_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam logic OWNER_D  = 1'b0;
   localparam logic OWNER_I  = 1'b1;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   // The instruction path can only ever read.
   function automatic logic grant_rw(input logic owner, input logic d_rw);
      return (owner == OWNER_I) ? RW_READ : d_rw;
   endfunction

endpackage

// File: rtl/axi_arb_fair_sel.sv
// Grant selection between data and instruction requesters, with a saturating
// count of consecutive data grants that lets a waiting instruction refill through.
module axi_arb_fair_sel #(
   parameter int MAX_D_GRANTS = 4
) (
   input  logic Clk,
   input  logic Rst,
   input  logic arb_en,
   input  logic d_req,
   input  logic i_req,
   output logic grant_valid,
   output logic grant_owner
);
   import axi_port_arbiter_pkg::*;

   localparam int CNT_W = $clog2(MAX_D_GRANTS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_GRANTS);

   logic [CNT_W-1:0] d_streak;
   logic             d_ok;

   // Data wins unless an instruction request has already waited out the streak limit.
   always_comb begin
      d_ok        = d_req && (!i_req || (d_streak < CNT_MAX));
      grant_valid = d_ok || i_req;
      grant_owner = d_ok ? OWNER_D : OWNER_I;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         d_streak <= '0;
      end else if (arb_en && grant_valid) begin
         if ((grant_owner == OWNER_I) || !i_req) begin
            d_streak <= '0;
         end else if (d_streak != CNT_MAX) begin
            d_streak <= d_streak + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/axi_port_arbiter.sv
// Shares one AXI master command port between the data and instruction-refill paths,
// one transaction at a time. Define AXI_ARB_TIMEOUT_EN to add the WAIT watchdog and Err ports.
module axi_port_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_D_GRANTS   = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  D_Req,
   input  logic                  D_RW,
   input  logic [ADDR_WIDTH-1:0] D_Addr,
   input  logic [DATA_WIDTH-1:0] D_WData,
   output logic [DATA_WIDTH-1:0] D_RData,
   output logic                  D_Done,
   input  logic                  I_Req,
   input  logic [ADDR_WIDTH-1:0] I_Addr,
   output logic [DATA_WIDTH-1:0] I_RData,
   output logic                  I_Done,
   output logic [ADDR_WIDTH-1:0] P_AXIAddr,
   output logic                  P_StartAXIRead,
   output logic                  P_StartAXIWrite,
   output logic [DATA_WIDTH-1:0] P_WriteData,
   input  logic [DATA_WIDTH-1:0] P_ReadData,
   input  logic                  P_ReadCompleted,
   input  logic                  P_WriteCompleted,
`ifdef AXI_ARB_TIMEOUT_EN
   output logic                  D_Err,
   output logic                  I_Err,
`endif
   output logic                  Busy,
   output logic                  Owner
);
   import axi_port_arbiter_pkg::*;

   arb_state_t state;
   logic       rw_q;
   logic       grant_valid;
   logic       grant_owner;
   logic       txn_rw;
   logic       strobe_match;
   logic       timed_out;

   axi_arb_fair_sel #(
      .MAX_D_GRANTS(MAX_D_GRANTS)
   ) u_fair_sel (
      .Clk        (Clk),
      .Rst        (Rst),
      .arb_en     (state == IDLE),
      .d_req      (D_Req),
      .i_req      (I_Req),
      .grant_valid(grant_valid),
      .grant_owner(grant_owner)
   );

   assign txn_rw = grant_rw(grant_owner, D_RW);

   // Only the strobe for the latched direction counts, and only while a transfer is in flight.
   assign strobe_match = ((state == ISSUE) || (state == WAIT)) &&
                         ((rw_q == RW_WRITE) ? P_WriteCompleted : P_ReadCompleted);

`ifdef AXI_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] wait_cnt;

   assign timed_out = (state == WAIT) && !strobe_match && (wait_cnt == TO_LAST);

   // Watchdog counts cycles spent in WAIT; Err pulses alongside the owner's Done.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         wait_cnt <= '0;
         D_Err    <= 1'b0;
         I_Err    <= 1'b0;
      end else begin
         D_Err <= timed_out && (Owner == OWNER_D);
         I_Err <= timed_out && (Owner == OWNER_I);
         if (state == WAIT) begin
            wait_cnt <= wait_cnt + TO_W'(1);
         end else begin
            wait_cnt <= '0;
         end
      end
   end
`else
   assign timed_out = 1'b0;
`endif

   // Transaction FSM: latch the winner in IDLE, pulse the start in ISSUE, finish on the matching strobe.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state           <= IDLE;
         Owner           <= OWNER_D;
         rw_q            <= RW_READ;
         P_AXIAddr       <= '0;
         P_WriteData     <= '0;
         P_StartAXIRead  <= 1'b0;
         P_StartAXIWrite <= 1'b0;
         D_Done          <= 1'b0;
         I_Done          <= 1'b0;
         D_RData         <= '0;
         I_RData         <= '0;
         Busy            <= 1'b0;
      end else begin
         P_StartAXIRead  <= 1'b0;
         P_StartAXIWrite <= 1'b0;
         D_Done          <= 1'b0;
         I_Done          <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  Owner           <= grant_owner;
                  rw_q            <= txn_rw;
                  P_AXIAddr       <= (grant_owner == OWNER_I) ? I_Addr : D_Addr;
                  P_WriteData     <= (txn_rw == RW_WRITE) ? D_WData : '0;
                  P_StartAXIRead  <= (txn_rw == RW_READ);
                  P_StartAXIWrite <= (txn_rw == RW_WRITE);
                  Busy            <= 1'b1;
                  state           <= ISSUE;
               end
            end
            ISSUE, WAIT: begin
               if (strobe_match || timed_out) begin
                  if (Owner == OWNER_D) begin
                     D_Done <= 1'b1;
                     if (timed_out) begin
                        D_RData <= '1;
                     end else if (rw_q == RW_READ) begin
                        D_RData <= P_ReadData;
                     end
                  end else begin
                     I_Done <= 1'b1;
                     if (timed_out) begin
                        I_RData <= '1;
                     end else if (rw_q == RW_READ) begin
                        I_RData <= P_ReadData;
                     end
                  end
                  state <= DONE;
               end else begin
                  state <= WAIT;
               end
            end
            DONE: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_port_arbiter.sv
// Directed bench for axi_port_arbiter: write, read, contention order, mismatched strobe,
// reset mid-transfer and (with AXI_ARB_TIMEOUT_EN) the WAIT watchdog.
module tb_axi_port_arbiter;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        D_Req = 1'b0;
   logic        D_RW = 1'b0;
   logic [31:0] D_Addr = '0;
   logic [31:0] D_WData = '0;
   logic [31:0] D_RData;
   logic        D_Done;
   logic        I_Req = 1'b0;
   logic [31:0] I_Addr = '0;
   logic [31:0] I_RData;
   logic        I_Done;
   logic [31:0] P_AXIAddr;
   logic        P_StartAXIRead;
   logic        P_StartAXIWrite;
   logic [31:0] P_WriteData;
   logic [31:0] P_ReadData = '0;
   logic        P_ReadCompleted = 1'b0;
   logic        P_WriteCompleted = 1'b0;
`ifdef AXI_ARB_TIMEOUT_EN
   logic        D_Err;
   logic        I_Err;
`endif
   logic        Busy;
   logic        Owner;

   int vectors = 0;
   int miscompares = 0;
   int starts;
   int dones;
   int budget;
   logic [9:0] expOrder;

   axi_port_arbiter #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .MAX_D_GRANTS  (4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .D_Req           (D_Req),
      .D_RW            (D_RW),
      .D_Addr          (D_Addr),
      .D_WData         (D_WData),
      .D_RData         (D_RData),
      .D_Done          (D_Done),
      .I_Req           (I_Req),
      .I_Addr          (I_Addr),
      .I_RData         (I_RData),
      .I_Done          (I_Done),
      .P_AXIAddr       (P_AXIAddr),
      .P_StartAXIRead  (P_StartAXIRead),
      .P_StartAXIWrite (P_StartAXIWrite),
      .P_WriteData     (P_WriteData),
      .P_ReadData      (P_ReadData),
      .P_ReadCompleted (P_ReadCompleted),
      .P_WriteCompleted(P_WriteCompleted),
`ifdef AXI_ARB_TIMEOUT_EN
      .D_Err           (D_Err),
      .I_Err           (I_Err),
`endif
      .Busy            (Busy),
      .Owner           (Owner)
   );

   always #5 Clk = ~Clk;

   // Advance n clock edges and settle 1 time unit past the last one.
   task automatic applyStimulus(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset: every output at zero.
      #2 Rst = 1'b0;
      applyStimulus(2);
      checkOutput("reset busy", 32'(Busy), 32'd0);
      checkOutput("reset owner", 32'(Owner), 32'd0);
      checkOutput("reset starts", 32'({P_StartAXIRead, P_StartAXIWrite}), 32'd0);
      checkOutput("reset dones", 32'({D_Done, I_Done}), 32'd0);
      checkOutput("reset addr", P_AXIAddr, 32'd0);
      checkOutput("reset rdata", D_RData | I_RData | P_WriteData, 32'd0);
      Rst = 1'b1;
      applyStimulus(1);

      // Single data write, completion strobe five cycles after the start pulse.
      D_Req = 1'b1; D_RW = 1'b1; D_Addr = 32'h4000_0010; D_WData = 32'hDEAD_BEEF;
      applyStimulus(1);
      checkOutput("wr start write", 32'(P_StartAXIWrite), 32'd1);
      checkOutput("wr start read", 32'(P_StartAXIRead), 32'd0);
      checkOutput("wr addr", P_AXIAddr, 32'h4000_0010);
      checkOutput("wr data", P_WriteData, 32'hDEAD_BEEF);
      checkOutput("wr owner busy", 32'({Owner, Busy}), 32'b01);
      starts = 1; dones = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1);
         starts += 32'(P_StartAXIWrite) + 32'(P_StartAXIRead);
         dones  += 32'(D_Done) + 32'(I_Done);
      end
      checkOutput("wr single start", 32'(starts), 32'd1);
      checkOutput("wr no early done", 32'(dones), 32'd0);
      P_WriteCompleted = 1'b1;
      applyStimulus(1);
      P_WriteCompleted = 1'b0; D_Req = 1'b0;
      checkOutput("wr d_done", 32'(D_Done), 32'd1);
      checkOutput("wr i_done", 32'(I_Done), 32'd0);
      checkOutput("wr addr stable", P_AXIAddr, 32'h4000_0010);
      checkOutput("wr data stable", P_WriteData, 32'hDEAD_BEEF);
      applyStimulus(1);
      checkOutput("wr back idle", 32'({Busy, D_Done}), 32'd0);

      // Data read with a mismatched write strobe in the middle.
      D_Req = 1'b1; D_RW = 1'b0; D_Addr = 32'h4000_0020;
      applyStimulus(1);
      checkOutput("rd start read", 32'({P_StartAXIRead, P_StartAXIWrite}), 32'b10);
      applyStimulus(1);
      P_WriteCompleted = 1'b1;
      applyStimulus(1);
      P_WriteCompleted = 1'b0;
      checkOutput("mismatch ignored done", 32'(D_Done), 32'd0);
      applyStimulus(1);
      checkOutput("mismatch still busy", 32'({Busy, D_Done}), 32'b10);
      P_ReadCompleted = 1'b1; P_ReadData = 32'h1234_5678;
      applyStimulus(1);
      P_ReadCompleted = 1'b0; D_Req = 1'b0;
      checkOutput("rd d_done", 32'({D_Done, I_Done}), 32'b10);
      checkOutput("rd d_rdata", D_RData, 32'h1234_5678);
      applyStimulus(1);

      // Single instruction read.
      I_Req = 1'b1; I_Addr = 32'h0000_0100;
      applyStimulus(1);
      checkOutput("ird starts", 32'({P_StartAXIRead, P_StartAXIWrite}), 32'b10);
      checkOutput("ird owner", 32'(Owner), 32'd1);
      checkOutput("ird addr", P_AXIAddr, 32'h0000_0100);
      applyStimulus(1);
      P_ReadCompleted = 1'b1; P_ReadData = 32'hCAFE_F00D;
      applyStimulus(1);
      P_ReadCompleted = 1'b0; I_Req = 1'b0;
      checkOutput("ird dones", 32'({D_Done, I_Done}), 32'b01);
      checkOutput("ird i_rdata", I_RData, 32'hCAFE_F00D);
      checkOutput("ird d_rdata kept", D_RData, 32'h1234_5678);
      applyStimulus(1);

      // Contention with immediate completions: four data grants, then one instruction.
      expOrder = 10'b10_0001_0000;
      D_Req = 1'b1; D_RW = 1'b0; D_Addr = 32'h4000_0100;
      I_Req = 1'b1; I_Addr = 32'h0000_0200;
      for (int t = 0; t < 10; t++) begin
         budget = 0;
         applyStimulus(1);
         while (!(P_StartAXIRead || P_StartAXIWrite) && budget < 8) begin
            applyStimulus(1);
            budget++;
         end
         checkOutput($sformatf("cont start %0d", t), 32'(budget < 8), 32'd1);
         checkOutput($sformatf("cont grant %0d", t), 32'(Owner), 32'(expOrder[t]));
         P_ReadCompleted = 1'b1; P_ReadData = 32'hA000_0000 + 32'(t);
         applyStimulus(1);
         P_ReadCompleted = 1'b0;
         checkOutput($sformatf("cont done %0d", t), 32'({D_Done, I_Done}),
                     expOrder[t] ? 32'b01 : 32'b10);
      end
      D_Req = 1'b0; I_Req = 1'b0;
      checkOutput("cont last i_rdata", I_RData, 32'hA000_0009);
      applyStimulus(1);

      // Reset during WAIT, then a stale strobe from the abandoned transfer.
      I_Req = 1'b1; I_Addr = 32'h0000_0300;
      applyStimulus(2);
      checkOutput("rst pre busy", 32'({Busy, Owner}), 32'b11);
      Rst = 1'b0;
      #1;
      I_Req = 1'b0;
      checkOutput("rst busy owner", 32'({Busy, Owner}), 32'd0);
      checkOutput("rst addr", P_AXIAddr, 32'd0);
      checkOutput("rst rdata", D_RData | I_RData, 32'd0);
      applyStimulus(1);
      Rst = 1'b1;
      P_ReadCompleted = 1'b1; P_ReadData = 32'h5555_AAAA;
      applyStimulus(1);
      P_ReadCompleted = 1'b0;
      applyStimulus(1);
      checkOutput("stale no done", 32'({D_Done, I_Done, Busy}), 32'd0);
      checkOutput("stale rdata", I_RData, 32'd0);
      D_Req = 1'b1; D_RW = 1'b1; D_Addr = 32'h4000_0030; D_WData = 32'h0BAD_F00D;
      applyStimulus(1);
      checkOutput("post rst start", 32'({P_StartAXIRead, P_StartAXIWrite}), 32'b01);
      checkOutput("post rst addr", P_AXIAddr, 32'h4000_0030);
      P_WriteCompleted = 1'b1;
      applyStimulus(1);
      P_WriteCompleted = 1'b0; D_Req = 1'b0;
      checkOutput("post rst issue done", 32'({D_Done, I_Done}), 32'b10);
      applyStimulus(1);

`ifdef AXI_ARB_TIMEOUT_EN
      // Data read that never completes: watchdog fires after 16 WAIT cycles.
      D_Req = 1'b1; D_RW = 1'b0; D_Addr = 32'h4000_0040;
      applyStimulus(2);
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1);
         dones += 32'(D_Done) + 32'(D_Err);
      end
      checkOutput("to no early done", 32'(dones), 32'd0);
      applyStimulus(1);
      D_Req = 1'b0;
      checkOutput("to done err", 32'({D_Done, D_Err, I_Done, I_Err}), 32'b1100);
      checkOutput("to rdata", D_RData, 32'hFFFF_FFFF);
      applyStimulus(1);
      checkOutput("to idle", 32'({Busy, D_Done, D_Err}), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
